// File: rtl/pe_id_config_loader.sv
// Snapshots the PE-array ID tables on start and streams them, one word per
// valid/ready handshake, onto the PE-array ID config bus.
module pe_id_config_loader #(
    parameter int NUM_ROWS = 6,
    parameter int NUM_COLS = 8,
    parameter int XID_W    = 5,
    parameter int YID_W    = 3,
    parameter int LN_W     = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] filter_xid,
    input  logic [NUM_ROWS*YID_W-1:0]          filter_yid,
    input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] ifmap_xid,
    input  logic [NUM_ROWS*YID_W-1:0]          ifmap_yid,
    input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] ipsum_xid,
    input  logic [NUM_ROWS*YID_W-1:0]          ipsum_yid,
    input  logic [NUM_ROWS*NUM_COLS*XID_W-1:0] opsum_xid,
    input  logic [NUM_ROWS*YID_W-1:0]          opsum_yid,
    input  logic [LN_W-1:0]                    ln_config,
    output logic                               busy,
    output logic                               done,
    output logic                               cfg_valid,
    input  logic                               cfg_ready,
    output logic [2:0]                         cfg_sel,
    output logic                               cfg_is_y,
    output logic [5:0]                         cfg_addr,
    output logic [XID_W-1:0]                   cfg_data
);

    localparam int NUM_PE  = NUM_ROWS * NUM_COLS;
    localparam int NUM_BUS = 4;
    localparam int XA_W    = $clog2(NUM_PE);
    localparam int YA_W    = $clog2(NUM_ROWS);

    localparam logic [5:0] Y_LAST    = 6'(NUM_ROWS - 1);
    localparam logic [5:0] X_LAST    = 6'(NUM_PE - 1);
    localparam logic [2:0] SEL_OPSUM = 3'd3;
    localparam logic [2:0] SEL_LN    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sel_q,   sel_d;
    logic       is_y_q,  is_y_d;
    logic [5:0] addr_q,  addr_d;
    logic       load;

    logic [XID_W-1:0] xid_q [NUM_BUS][NUM_PE];
    logic [YID_W-1:0] yid_q [NUM_BUS][NUM_ROWS];
    logic [LN_W-1:0]  ln_q;

    logic [NUM_PE*XID_W-1:0]   xid_in [NUM_BUS];
    logic [NUM_ROWS*YID_W-1:0] yid_in [NUM_BUS];

    assign xid_in[0] = filter_xid;
    assign xid_in[1] = ifmap_xid;
    assign xid_in[2] = ipsum_xid;
    assign xid_in[3] = opsum_xid;
    assign yid_in[0] = filter_yid;
    assign yid_in[1] = ifmap_yid;
    assign yid_in[2] = ipsum_yid;
    assign yid_in[3] = opsum_yid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            is_y_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            is_y_q  <= is_y_d;
            addr_q  <= addr_d;
        end
    end

    // Snapshot decouples the stream from the generator, whose inputs may move on after start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NUM_BUS; b++) begin
                for (int unsigned i = 0; i < NUM_PE; i++) xid_q[b][i] <= '0;
                for (int unsigned j = 0; j < NUM_ROWS; j++) yid_q[b][j] <= '0;
            end
            ln_q <= '0;
        end else if (load) begin
            for (int unsigned b = 0; b < NUM_BUS; b++) begin
                for (int unsigned i = 0; i < NUM_PE; i++)
                    xid_q[b][i] <= xid_in[b][i*XID_W +: XID_W];
                for (int unsigned j = 0; j < NUM_ROWS; j++)
                    yid_q[b][j] <= yid_in[b][j*YID_W +: YID_W];
            end
            ln_q <= ln_config;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        is_y_d    = is_y_q;
        addr_d    = addr_q;
        load      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cfg_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                    sel_d   = '0;
                    is_y_d  = 1'b1;
                    addr_d  = '0;
                end
            end
            ST_SEND: begin
                busy      = 1'b1;
                cfg_valid = 1'b1;
                if (cfg_ready) begin
                    if (sel_q == SEL_LN) begin
                        state_d = ST_DONE;
                        sel_d   = '0;
                        is_y_d  = 1'b0;
                        addr_d  = '0;
                    end else if (is_y_q) begin
                        if (addr_q == Y_LAST) begin
                            is_y_d = 1'b0;
                            addr_d = '0;
                        end else begin
                            addr_d = addr_q + 6'd1;
                        end
                    end else if (addr_q == X_LAST) begin
                        addr_d = '0;
                        if (sel_q == SEL_OPSUM) begin
                            sel_d  = SEL_LN;
                            is_y_d = 1'b0;
                        end else begin
                            sel_d  = sel_q + 3'd1;
                            is_y_d = 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + 6'd1;
                    end
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_data = '0;
        if (state_q == ST_SEND) begin
            if (sel_q == SEL_LN)
                cfg_data = XID_W'(ln_q);
            else if (is_y_q)
                cfg_data = XID_W'(yid_q[sel_q[1:0]][addr_q[YA_W-1:0]]);
            else
                cfg_data = xid_q[sel_q[1:0]][addr_q[XA_W-1:0]];
        end
    end

    assign cfg_sel  = sel_q;
    assign cfg_is_y = is_y_q;
    assign cfg_addr = addr_q;

endmodule
